// File: rtl/bb_loop_filter_if.sv
// Handshake bundle between the loop filter and its environment: link enable,
// comparator decision in; tuning word, update strobe, lock status and state out.
interface bb_loop_filter_if #(
  parameter int W = 16
);
  logic         swiptAlive;
  logic         ADC_comp;
  logic [W-1:0] ctrl_word;
  logic         ctrl_valid;
  logic         locked;
  logic [1:0]   state;

  modport master (
    output swiptAlive, ADC_comp,
    input  ctrl_word, ctrl_valid, locked, state
  );

  modport slave (
    input  swiptAlive, ADC_comp,
    output ctrl_word, ctrl_valid, locked, state
  );
endinterface

// File: rtl/bb_loop_filter.sv
// Bang-bang PI loop filter: integrates 1-bit early/late decisions into a saturating
// DCO tuning word, switching between acquisition and tracking gains on lock.
module bb_loop_filter #(
  parameter int           SAMPLE_DIV = 200,
  parameter int           W          = 16,
  parameter logic [W-1:0] INIT_WORD  = 16'h8000,
  parameter int           KP_ACQ     = 64,
  parameter int           KI_ACQ     = 16,
  parameter int           KP_TRK     = 8,
  parameter int           KI_TRK     = 1,
  parameter int           LOCK_N     = 8,
  parameter int           LOSS_N     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  bb_loop_filter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2} state_t;

  localparam int DIV_W = (SAMPLE_DIV > 0) ? $clog2(SAMPLE_DIV + 1) : 1;
  localparam int CNT_W = $clog2(LOCK_N + LOSS_N + 1);
  localparam logic signed [W+1:0] MAXV = {2'b00, {W{1'b1}}};

  state_t             state_q, state_d;
  logic [W-1:0]       integ_q, integ_d;
  logic [W-1:0]       word_q, word_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   tog_q, tog_d;
  logic [CNT_W-1:0]   same_q, same_d;
  logic               first_q, first_d;
  logic               prev_q, prev_d;

  logic signed [W+1:0] kp, ki, integ_ext, integ_n_ext;
  logic [W-1:0]        integ_n, word_n;
  logic                dec;

  // Clamp a widened signed result into the unsigned tuning-word range
  function automatic logic [W-1:0] sat(input logic signed [W+1:0] x);
    if (x < 0)         return '0;
    else if (x > MAXV) return '1;
    else               return x[W-1:0];
  endfunction

  // Gains follow the state held before the update edge
  assign kp          = (state_q == TRACK) ? (W+2)'(KP_TRK) : (W+2)'(KP_ACQ);
  assign ki          = (state_q == TRACK) ? (W+2)'(KI_TRK) : (W+2)'(KI_ACQ);
  assign dec         = bus.ADC_comp;
  assign integ_ext   = $signed({2'b00, integ_q});
  assign integ_n     = sat(dec ? integ_ext + ki : integ_ext - ki);
  assign integ_n_ext = $signed({2'b00, integ_n});
  assign word_n      = sat(dec ? integ_n_ext + kp : integ_n_ext - kp);

  always_comb begin
    state_d = state_q;
    integ_d = integ_q;
    word_d  = word_q;
    valid_d = 1'b0;
    div_d   = div_q;
    tog_d   = tog_q;
    same_d  = same_q;
    first_d = first_q;
    prev_d  = prev_q;

    if (state_q == ACQUIRE || state_q == TRACK) begin
      if (div_q == '0) begin
        div_d   = DIV_W'(SAMPLE_DIV);
        integ_d = integ_n;
        word_d  = word_n;
        valid_d = 1'b1;
        prev_d  = dec;
        if (first_q) begin
          tog_d   = '0;
          same_d  = CNT_W'(1);
          first_d = 1'b0;
        end else if (dec != prev_q) begin
          tog_d  = (tog_q >= CNT_W'(LOCK_N)) ? CNT_W'(LOCK_N) : tog_q + 1'b1;
          same_d = CNT_W'(1);
        end else begin
          same_d = (same_q >= CNT_W'(LOSS_N)) ? CNT_W'(LOSS_N) : same_q + 1'b1;
          tog_d  = '0;
        end
        if (state_q == ACQUIRE && tog_d == CNT_W'(LOCK_N)) begin
          state_d = TRACK;
        end else if (state_q == TRACK && same_d == CNT_W'(LOSS_N)) begin
          state_d = ACQUIRE;
          tog_d   = '0;
          same_d  = '0;
        end
      end else begin
        div_d = div_q - 1'b1;
      end
    end else begin
      // Leaving IDLE: the divider holds its reload value on this edge
      state_d = ACQUIRE;
      div_d   = DIV_W'(SAMPLE_DIV);
    end

    locked_d = (state_d == TRACK);
  end

  // Link loss is treated exactly like reset and overrides a coincident update
  always_ff @(posedge clk) begin
    if (!nrst || !bus.swiptAlive) begin
      state_q  <= IDLE;
      integ_q  <= INIT_WORD;
      word_q   <= INIT_WORD;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      div_q    <= DIV_W'(SAMPLE_DIV);
      tog_q    <= '0;
      same_q   <= '0;
      first_q  <= 1'b1;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      integ_q  <= integ_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      div_q    <= div_d;
      tog_q    <= tog_d;
      same_q   <= same_d;
      first_q  <= first_d;
      prev_q   <= prev_d;
    end
  end

  assign bus.ctrl_word  = word_q;
  assign bus.ctrl_valid = valid_q;
  assign bus.locked     = locked_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_bb_loop_filter.sv
// Directed bench for bb_loop_filter: main instance with default gains plus two
// instances started near the rails to exercise saturation.
module tb_bb_loop_filter;
  logic clk = 1'b0;
  logic nrst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  always #5 clk = ~clk;

  bb_loop_filter_if #(.W(16)) m  ();
  bb_loop_filter_if #(.W(16)) hi ();
  bb_loop_filter_if #(.W(16)) lo ();

  bb_loop_filter u_main (.clk(clk), .nrst(nrst), .bus(m));
  bb_loop_filter #(.INIT_WORD(16'hFFF8)) u_hi (.clk(clk), .nrst(nrst), .bus(hi));
  bb_loop_filter #(.INIT_WORD(16'h0008)) u_lo (.clk(clk), .nrst(nrst), .bus(lo));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Steps until the main instance strobes ctrl_valid, returning the cycle count
  task automatic wait_upd(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!m.ctrl_valid && n < 400);
    check("upd_seen", {31'd0, m.ctrl_valid}, 32'd1);
  endtask

  initial begin
    nrst = 1'b0;
    m.swiptAlive = 1'b1;  m.ADC_comp = 1'b1;
    hi.swiptAlive = 1'b1; hi.ADC_comp = 1'b1;
    lo.swiptAlive = 1'b1; lo.ADC_comp = 1'b0;
    repeat (5) step();

    // Reset state
    check("rst_state",  {30'd0, m.state}, 32'd0);
    check("rst_word",   {16'd0, m.ctrl_word}, 32'h8000);
    check("rst_valid",  {31'd0, m.ctrl_valid}, 32'd0);
    check("rst_locked", {31'd0, m.locked}, 32'd0);
    check("rst_hi",     {16'd0, hi.ctrl_word}, 32'hFFF8);
    check("rst_lo",     {16'd0, lo.ctrl_word}, 32'h0008);

    nrst = 1'b1;
    step();
    check("acq_state", {30'd0, m.state}, 32'd1);
    check("acq_word",  {16'd0, m.ctrl_word}, 32'h8000);

    // Constant 1 decisions
    wait_upd(lat);
    check("first_lat", lat, 32'd201);
    check("u1_word",   {16'd0, m.ctrl_word}, 32'h8050);
    check("hi_u1",     {16'd0, hi.ctrl_word}, 32'hFFFF);
    check("lo_u1",     {16'd0, lo.ctrl_word}, 32'h0000);
    step();
    check("valid_pulse", {31'd0, m.ctrl_valid}, 32'd0);
    check("word_hold",   {16'd0, m.ctrl_word}, 32'h8050);
    wait_upd(lat);
    check("u2_lat",    lat, 32'd200);
    check("u2_word",   {16'd0, m.ctrl_word}, 32'h8060);
    check("u2_locked", {31'd0, m.locked}, 32'd0);
    check("hi_u2",     {16'd0, hi.ctrl_word}, 32'hFFFF);
    check("lo_u2",     {16'd0, lo.ctrl_word}, 32'h0000);

    // Link drop on the edge where the next update is due
    repeat (200) step();
    check("pre_drop_valid", {31'd0, m.ctrl_valid}, 32'd0);
    m.swiptAlive = 1'b0;
    step();
    check("drop_valid",  {31'd0, m.ctrl_valid}, 32'd0);
    check("drop_word",   {16'd0, m.ctrl_word}, 32'h8000);
    check("drop_state",  {30'd0, m.state}, 32'd0);
    check("drop_locked", {31'd0, m.locked}, 32'd0);
    step();
    m.swiptAlive = 1'b1;
    m.ADC_comp = 1'b1;
    step();
    check("reacq_state", {30'd0, m.state}, 32'd1);

    // Alternating decisions from a fresh start
    wait_upd(lat);
    check("reacq_lat", lat, 32'd201);
    check("alt1_word", {16'd0, m.ctrl_word}, 32'h8050);
    for (int i = 2; i <= 8; i++) begin
      m.ADC_comp = i[0];
      wait_upd(lat);
      check("alt_word",   {16'd0, m.ctrl_word}, i[0] ? 32'h8050 : 32'h7FC0);
      check("alt_locked", {31'd0, m.locked}, 32'd0);
    end
    m.ADC_comp = 1'b1;
    wait_upd(lat);
    check("u9_locked", {31'd0, m.locked}, 32'd1);
    check("u9_state",  {30'd0, m.state}, 32'd2);
    check("u9_word",   {16'd0, m.ctrl_word}, 32'h8050);
    m.ADC_comp = 1'b0;
    wait_upd(lat);
    check("u10_word", {16'd0, m.ctrl_word}, 32'h8007);

    // Sixteen identical decisions in TRACK drop back to ACQUIRE
    m.ADC_comp = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      wait_upd(lat);
      check("trk_word",  {16'd0, m.ctrl_word}, 32'h800F + i + 8);
      check("trk_state", {30'd0, m.state}, 32'd2);
    end
    wait_upd(lat);
    check("loss_state",  {30'd0, m.state}, 32'd1);
    check("loss_locked", {31'd0, m.locked}, 32'd0);
    check("loss_word",   {16'd0, m.ctrl_word}, 32'h8027);
    wait_upd(lat);
    check("post_loss_word",  {16'd0, m.ctrl_word}, 32'h806F);
    check("post_loss_state", {30'd0, m.state}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
